// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction-bundle queue between IF and ID.
// Buffers fetched bundles (instruction, PC+4, PC+8, delay-slot flag, fetch
// ExcCode) so IF can keep fetching while ID stalls. Interrupts, exceptions and
// eret discard every wrong-path entry at the next edge.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                Instr_F,
  input  logic [31:0]                PC4_F,
  input  logic [31:0]                PC8_F,
  input  logic                       BD_F,
  input  logic [4:0]                 ExcCode_F,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic                       d_ready,
  input  logic                       flush,
  input  logic                       eret_kill,
  output logic [31:0]                Instr_D,
  output logic [31:0]                PC4_D,
  output logic [31:0]                PC8_D,
  output logic                       BD_D,
  output logic [4:0]                 ExcCode_D,
  output logic                       d_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 32 + 32 + 32 + 1 + 5;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Bundle layout in storage: {instr, pc4, pc8, bd, exccode}.
  function automatic logic [BW-1:0] pack_bundle(
    input logic [31:0] instr,
    input logic [31:0] pc4,
    input logic [31:0] pc8,
    input logic        bd,
    input logic [4:0]  exc
  );
    return {instr, pc4, pc8, bd, exc};
  endfunction

  logic [BW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          kill_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [BW-1:0] head_s;

  // Handshake qualification; fullness comes only from the registered count,
  // so d_ready never reaches f_ready combinationally.
  always_comb begin
    kill_s  = flush | eret_kill;
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {CW{1'b0}});
    push_s  = f_valid & ~full_s & ~kill_s;
    pop_s   = ~empty_s & d_ready & ~kill_s;
  end

  // Pointer and occupancy bookkeeping: reset, then kill, then push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (kill_s) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Bundle storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= pack_bundle(Instr_F, PC4_F, PC8_F, BD_F, ExcCode_F);
    end
  end

  // Head presentation: an empty queue shows an all-zero bundle, i.e. a nop.
  always_comb begin
    head_s = {BW{1'b0}};
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = {BW{1'b0}};
    end
  end

  // Unpack the head bundle and drive the status outputs.
  always_comb begin
    Instr_D   = head_s[BW-1 -: 32];
    PC4_D     = head_s[BW-33 -: 32];
    PC8_D     = head_s[BW-65 -: 32];
    BD_D      = head_s[5];
    ExcCode_D = head_s[4:0];
    d_valid   = ~empty_s;
    f_ready   = ~full_s;
    count     = count_r;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   Instr_F, PC4_F, PC8_F;
  logic          BD_F;
  logic [4:0]    ExcCode_F;
  logic          f_valid, f_ready, d_ready, flush, eret_kill;
  logic [31:0]   Instr_D, PC4_D, PC8_D;
  logic          BD_D;
  logic [4:0]    ExcCode_D;
  logic          d_valid;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of bundles {instr, pc4, pc8, bd, exccode}.
  logic [101:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .Instr_F(Instr_F), .PC4_F(PC4_F), .PC8_F(PC8_F), .BD_F(BD_F),
    .ExcCode_F(ExcCode_F), .f_valid(f_valid), .f_ready(f_ready),
    .d_ready(d_ready), .flush(flush), .eret_kill(eret_kill),
    .Instr_D(Instr_D), .PC4_D(PC4_D), .PC8_D(PC8_D), .BD_D(BD_D),
    .ExcCode_D(ExcCode_D), .d_valid(d_valid), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the block's rules to the model for the edge that just occurred.
  task automatic model_edge();
    bit kill, push, pop;
    kill = flush | eret_kill;
    push = f_valid && (mq.size() < DEPTH) && !kill;
    pop  = (mq.size() > 0) && d_ready && !kill;
    if (reset || kill) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({Instr_F, PC4_F, PC8_F, BD_F, ExcCode_F});
    end
  endtask

  task automatic compare_all();
    logic [101:0] h;
    h = (mq.size() > 0) ? mq[0] : 102'd0;
    check_val("count",   32'(count),     32'(mq.size()));
    check_val("d_valid", 32'(d_valid),   32'(mq.size() > 0));
    check_val("f_ready", 32'(f_ready),   32'(mq.size() < DEPTH));
    check_val("Instr_D", Instr_D,        h[101:70]);
    check_val("PC4_D",   PC4_D,          h[69:38]);
    check_val("PC8_D",   PC8_D,          h[37:6]);
    check_val("BD_D",    32'(BD_D),      32'(h[5]));
    check_val("ExcCode", 32'(ExcCode_D), 32'(h[4:0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input logic fv, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic bd, input logic [4:0] exc, input logic dr,
                        input logic fl, input logic ek);
    f_valid = fv; Instr_F = instr; PC4_F = pc4; PC8_F = pc4 + 32'd4;
    BD_F = bd; ExcCode_F = exc; d_ready = dr; flush = fl; eret_kill = ek;
  endtask

  task automatic idle(input logic dr);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, dr, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0);
    step(); step();
    reset = 1'b0;
    idle(1'b0);
    step();
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_fready", 32'(f_ready), 32'd1);

    // Single push held while ID stalls.
    set_in(1'b1, 32'h2401_0001, 32'h0000_3004, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_val("t1_instr", Instr_D, 32'h2401_0001);
    check_val("t1_pc8", PC8_D, 32'h0000_3008);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t1_hold", Instr_D, 32'h2401_0001);
    end

    // Fill to capacity; third bundle rejected, then drain A, B.
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b1, 32'hAAAA_0000, 32'h100, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    set_in(1'b1, 32'hBBBB_0000, 32'h104, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    check_val("t2_fready", 32'(f_ready), 32'd0);
    set_in(1'b1, 32'hCCCC_0000, 32'h108, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    check_val("t2_count", 32'(count), 32'd2);
    idle(1'b1);
    check_val("t2_A", Instr_D, 32'hAAAA_0000);
    step(); check_val("t2_B", Instr_D, 32'hBBBB_0000);
    step(); check_val("t2_empty", Instr_D, 32'h0);

    // Steady stream of 8 bundles through the wrap.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'h5000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      check_val("t3_count", 32'(count), 32'd1);
      check_val("t3_order", Instr_D, 32'h5000_0000 + 32'(i));
    end
    idle(1'b1); step();

    // Full queue flushed together with an incoming bundle.
    set_in(1'b1, 32'h1111_0000, 32'h300, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    set_in(1'b1, 32'h2222_0000, 32'h304, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    set_in(1'b1, 32'h3333_0000, 32'h308, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step();
    check_val("t4_count", 32'(count), 32'd0);
    check_val("t4_instr", Instr_D, 32'h0);
    idle(1'b0); step();
    check_val("t4_nodrop", 32'(d_valid), 32'd0);

    // eret kill with one entry, then EPC fetch.
    set_in(1'b1, 32'h4444_0000, 32'h400, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1); step();
    check_val("t5_count", 32'(count), 32'd0);
    set_in(1'b1, 32'h8000_0180, 32'h184, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    check_val("t5_epc", Instr_D, 32'h8000_0180);
    idle(1'b1); step();

    // ExcCode and BD carried unchanged.
    set_in(1'b1, 32'h0000_0000, 32'h0000_3001, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0); step();
    check_val("t6_exc", 32'(ExcCode_D), 32'd4);
    check_val("t6_bd", 32'(BD_D), 32'd1);
    check_val("t6_pc4", PC4_D, 32'h0000_3001);

    // Random traffic including occasional kills and resets.
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
             $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-entry (parameterisable) instruction queue between the IF stage and the ID stage of the pipelined MIPS core. It replaces the plain IF/ID register. The queue buffers fetched instruction bundles: instruction word, PC+4, PC+8, branch-delay flag and fetch ExcCode. This decouples the IF PC-enable from ID stalls. The queue discards wrong-path entries when an interrupt, exception or eret redirects fetch.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the queue.
- Instr_F  in  32  fetched instruction word.
- PC4_F  in  32  PC+4 of the fetched instruction.
- PC8_F  in  32  PC+8 of the fetched instruction.
- BD_F  in  1  fetched instruction sits in a branch delay slot.
- ExcCode_F  in  5  fetch exception code; 0 means none.
- f_valid  in  1  IF presents a bundle this cycle.
- f_ready  out  1  queue can accept a bundle; the IF PC enable is f_valid & f_ready.
- d_ready  in  1  ID consumes the head this cycle, i.e. it is not stalled.
- flush  in  1  interrupt or exception taken; kill everything.
- eret_kill  in  1  eret is in D; kill everything fetched behind it.
- Instr_D  out  32  head instruction; 32'h0000_0000 (nop) when empty.
- PC4_D  out  32  head PC+4; 0 when empty.
- PC8_D  out  32  head PC+8; 0 when empty.
- BD_D  out  1  head BD flag; 0 when empty.
- ExcCode_D  out  5  head ExcCode; 0 when empty.
- d_valid  out  1  head entry is valid.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH bundles, each 32+32+32+1+5 = 102 bits.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is a separate register and is never derived from the pointers.
- push = f_valid & f_ready & ~flush & ~eret_kill.
- pop = d_valid & d_ready & ~flush & ~eret_kill.
- f_ready = (count != DEPTH). It is based on the registered count only, so there is no combinational path from d_ready to f_ready.
- A full queue rejects a push even when a pop happens in the same cycle.
- d_valid = (count != 0).
- When d_valid = 1, the head fields come straight from storage at the read pointer.
- When d_valid = 0, Instr_D, PC4_D, PC8_D, BD_D and ExcCode_D are forced to 0, so ID decodes a nop.
- Push only: write the bundle at the write pointer, advance the write pointer, count+1.
- Pop only: advance the read pointer, count-1.
- Push and pop together: do both; count is unchanged.
- flush or eret_kill: both pointers and count go to 0, and the same-cycle f_valid bundle is dropped.
- flush and eret_kill are equivalent inside the block. Storage contents need not be cleared.
- Priority, highest first: reset, then flush/eret_kill, then push/pop.
- The queue never overflows or underflows. A push when full or a pop when empty is suppressed by the gating above.
- The ExcCode and BD fields are carried unchanged. Exception recognition happens in later stages.

## Timing
- Reset: pointers = 0, count = 0, d_valid = 0, f_ready = 1, and every D output is 0.
- Latency is one cycle. A bundle pushed at edge N appears on the D outputs after edge N with d_valid = 1. There is no same-cycle fall-through.
- Throughput is one bundle per cycle in steady state when DEPTH ≥ 2, because push and pop overlap.
- The ID stall response is immediate: with d_ready = 0 the head holds stable for any number of cycles.
- A kill takes effect at the next edge. In the cycle after flush or eret_kill, count = 0, d_valid = 0 and f_ready = 1.
- If reset is asserted mid-operation, all state is discarded at that edge.
- Pointer wrap: the entry after index DEPTH-1 is index 0. Order must be preserved across the wrap.

## Test plan
- Reset, then push 0x24010001 with PC4 = 0x3004 and PC8 = 0x3008, with d_ready = 0. Required: the next cycle shows d_valid = 1, Instr_D = 0x24010001, count = 1; the values hold while d_ready = 0.
- Push three bundles A, B, C on consecutive cycles with d_ready = 0. Required: f_ready = 0 after A and B; C is rejected; count = 2. Then raise d_ready. Required: the outputs are A, then B, then empty with Instr_D = 0.
- Steady stream of 8 bundles with d_ready = 1 and f_valid = 1. Required: in-order output at 1 per cycle, count stays at 1, and the order is correct across the pointer wraps.
- Queue full (2 entries) with flush asserted together with f_valid. Required: next cycle count = 0, d_valid = 0, all D outputs 0, f_ready = 1; the same-cycle bundle does not appear.
- One entry queued, eret_kill = 1, d_ready = 1. Required: nothing is popped to ID as valid; next cycle count = 0. A bundle pushed in the following cycle (the EPC fetch) appears the cycle after that.
- Push ExcCode = 4 and BD = 1 with PC4 = 0x3001. Required: ExcCode_D = 4, BD_D = 1 and PC4_D = 0x3001 on output, carried unchanged.
